// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM encoding and datapath widths.
package spi_pkg;

   localparam int DATA_W   = 8;
   localparam int BITCNT_W = 3;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus one delay flop; reports synced level and its rise/fall.
module spi_sync_edge (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic i_rst_val,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_dly;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // Reset value comes from a live input so an idle-high SCLK does not look like an edge after reset.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_meta <= i_rst_val;
         r_sync <= i_rst_val;
         r_dly  <= i_rst_val;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_dly  <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_sync & ~r_dly;
   assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave, all four modes, MSB/LSB first, oversampled on PCLK with single tx/rx byte buffers.
module spi_slave_core
   import spi_pkg::*;
(
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              spe,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsbfe,
   input  logic              sclk_in,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_empty,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_full,
   input  logic              rx_read,
   output logic              rx_ovf,
   input  logic              ovf_clr
);

   spi_state_e            r_state;
   spi_state_e            w_next;
   logic [DATA_W-1:0]     r_shift;
   logic [BITCNT_W-1:0]   r_bit_cnt;
   logic                  r_in_bit;
   logic [DATA_W-1:0]     r_tx_buf;
   logic                  r_tx_empty;
   logic [DATA_W-1:0]     r_rx_data;
   logic                  r_rx_full;
   logic                  r_rx_ovf;
   logic                  r_mosi_meta;
   logic                  r_mosi_sync;

   logic w_sclk, w_sclk_rise, w_sclk_fall;
   logic w_ss, w_ss_rise, w_ss_fall;
   logic w_unused;
   logic w_start, w_run, w_lead, w_trail;
   logic w_sample, w_shift, w_byte_done, w_reload, w_copy, w_tx_accept;
   logic [DATA_W-1:0] w_rx_byte;

   spi_sync_edge u_sclk_sync (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .i_rst_val (cpol),
      .i_async   (sclk_in),
      .o_sync    (w_sclk),
      .o_rise    (w_sclk_rise),
      .o_fall    (w_sclk_fall)
   );

   spi_sync_edge u_ss_sync (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .i_rst_val (1'b1),
      .i_async   (ss_n),
      .o_sync    (w_ss),
      .o_rise    (w_ss_rise),
      .o_fall    (w_ss_fall)
   );

   assign w_unused = w_sclk ^ w_ss_rise;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
      end else begin
         r_mosi_meta <= mosi;
         r_mosi_sync <= r_mosi_meta;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // NOTE: next-state is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_ss_fall && spe) w_next = ACTIVE;
         ACTIVE:  if (w_ss || !spe)     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_start     = (r_state == IDLE)   && (w_next == ACTIVE);
   assign w_run       = (r_state == ACTIVE) && (w_next == ACTIVE);
   assign w_lead      = cpol ? w_sclk_fall : w_sclk_rise;
   assign w_trail     = cpol ? w_sclk_rise : w_sclk_fall;
   assign w_sample    = w_run && (cpha ? w_trail : w_lead);
   // Count 0 means a byte was just loaded: its first bit is already on miso, so skip that shift.
   assign w_shift     = w_run && (cpha ? w_lead : w_trail) && (r_bit_cnt != '0);
   assign w_byte_done = w_sample && (r_bit_cnt == BITCNT_W'(DATA_W - 1));
   assign w_reload    = w_start || w_byte_done;
   assign w_copy      = w_reload && !r_tx_empty;
   assign w_tx_accept = tx_load && (r_tx_empty || w_copy);
   assign w_rx_byte   = lsbfe ? {r_mosi_sync, r_shift[DATA_W-1:1]}
                              : {r_shift[DATA_W-2:0], r_mosi_sync};

   // Sampled bit waits in r_in_bit and enters the register on the following shift edge,
   // so the outgoing bit at the far end is never overwritten before it is driven.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_shift   <= '0;
         r_in_bit  <= 1'b0;
         r_bit_cnt <= '0;
      end else begin
         if (w_reload)
            r_shift <= r_tx_empty ? '0 : r_tx_buf;
         else if (w_shift)
            r_shift <= lsbfe ? {r_in_bit, r_shift[DATA_W-1:1]}
                             : {r_shift[DATA_W-2:0], r_in_bit};
         if (w_sample)
            r_in_bit <= r_mosi_sync;
         if (w_next != ACTIVE || w_start)
            r_bit_cnt <= '0;
         else if (w_sample)
            r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_tx_buf   <= '0;
         r_tx_empty <= 1'b1;
      end else if (w_tx_accept) begin
         r_tx_buf   <= tx_data;
         r_tx_empty <= 1'b0;
      end else if (w_copy) begin
         r_tx_empty <= 1'b1;
      end
   end

   // A read in the same cycle as a completed byte frees the buffer first.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_rx_data <= '0;
         r_rx_full <= 1'b0;
         r_rx_ovf  <= 1'b0;
      end else begin
         if (w_byte_done && (!r_rx_full || rx_read)) begin
            r_rx_data <= w_rx_byte;
            r_rx_full <= 1'b1;
         end else if (rx_read) begin
            r_rx_full <= 1'b0;
         end
         if (w_byte_done && r_rx_full && !rx_read)
            r_rx_ovf <= 1'b1;
         else if (ovf_clr)
            r_rx_ovf <= 1'b0;
      end
   end

   assign miso     = (r_state == ACTIVE) ? (lsbfe ? r_shift[0] : r_shift[DATA_W-1]) : 1'b0;
   assign miso_oe  = (r_state == ACTIVE);
   assign tx_empty = r_tx_empty;
   assign rx_data  = r_rx_data;
   assign rx_full  = r_rx_full;
   assign rx_ovf   = r_rx_ovf;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: bench acts as SPI master and checks buffers and flags.
module tb_spi_slave_core;

   localparam int HALF = 8;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic       spe, cpol, cpha, lsbfe;
   logic       sclk_in, ss_n, mosi;
   logic       miso, miso_oe;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_empty;
   logic [7:0] rx_data;
   logic       rx_full;
   logic       rx_read;
   logic       rx_ovf;
   logic       ovf_clr;

   int checks = 0;
   int errors = 0;

   logic [7:0] mi_a, mi_b;

   spi_slave_core dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .spe      (spe),
      .cpol     (cpol),
      .cpha     (cpha),
      .lsbfe    (lsbfe),
      .sclk_in  (sclk_in),
      .ss_n     (ss_n),
      .mosi     (mosi),
      .miso     (miso),
      .miso_oe  (miso_oe),
      .tx_data  (tx_data),
      .tx_load  (tx_load),
      .tx_empty (tx_empty),
      .rx_data  (rx_data),
      .rx_full  (rx_full),
      .rx_read  (rx_read),
      .rx_ovf   (rx_ovf),
      .ovf_clr  (ovf_clr)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits half an SCLK period; optionally pulses rx_read exactly in the cycle
   // where the byte-complete pulse is seen (two PCLK after the driven edge).
   task automatic wait_half(input bit rd);
      for (int k = 0; k < HALF; k++) begin
         @(negedge PCLK);
         rx_read = (rd && k == 1);
      end
      rx_read = 1'b0;
   endtask

   task automatic pulse_load(input logic [7:0] v);
      @(negedge PCLK);
      tx_data = v;
      tx_load = 1'b1;
      @(negedge PCLK);
      tx_load = 1'b0;
   endtask

   task automatic pulse_read();
      @(negedge PCLK);
      rx_read = 1'b1;
      @(negedge PCLK);
      rx_read = 1'b0;
   endtask

   task automatic pulse_ovf_clr();
      @(negedge PCLK);
      ovf_clr = 1'b1;
      @(negedge PCLK);
      ovf_clr = 1'b0;
   endtask

   task automatic begin_frame();
      @(negedge PCLK);
      ss_n = 1'b0;
      wait_half(1'b0);
   endtask

   task automatic end_frame();
      wait_half(1'b0);
      ss_n = 1'b1;
      wait_half(1'b0);
   endtask

   task automatic xfer(input logic [7:0] mo, input int nbits, input bit rd, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         int b;
         b = lsbfe ? i : 7 - i;
         if (!cpha) begin
            mosi = mo[b];
            wait_half(1'b0);
            mi[b] = miso;
            sclk_in = ~cpol;
            wait_half(rd && i == nbits - 1);
            sclk_in = cpol;
         end else begin
            sclk_in = ~cpol;
            mosi = mo[b];
            wait_half(1'b0);
            mi[b] = miso;
            sclk_in = cpol;
            wait_half(rd && i == nbits - 1);
         end
      end
   endtask

   initial begin
      PRESETn = 1'b0;
      spe = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
      sclk_in = 1'b0; ss_n = 1'b1; mosi = 1'b0;
      tx_data = 8'h00; tx_load = 1'b0; rx_read = 1'b0; ovf_clr = 1'b0;
      repeat (3) @(negedge PCLK);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_full", rx_full, 1'b0);
      check("rst_rx_ovf", rx_ovf, 1'b0);
      check("rst_tx_empty", tx_empty, 1'b1);
      check("rst_miso", miso, 1'b0);
      check("rst_miso_oe", miso_oe, 1'b0);
      PRESETn = 1'b1;
      repeat (4) @(negedge PCLK);

      // Mode 0, MSB first: send A5, receive 3C
      pulse_load(8'hA5);
      check("m0_tx_full", tx_empty, 1'b0);
      begin_frame();
      check("m0_oe", miso_oe, 1'b1);
      check("m0_tx_copied", tx_empty, 1'b1);
      xfer(8'h3C, 8, 1'b0, mi_a);
      end_frame();
      check("m0_miso_byte", mi_a, 8'hA5);
      check("m0_rx_data", rx_data, 8'h3C);
      check("m0_rx_full", rx_full, 1'b1);
      check("m0_tx_empty", tx_empty, 1'b1);
      check("m0_oe_idle", miso_oe, 1'b0);
      pulse_read();
      check("m0_rx_read", rx_full, 1'b0);

      // Mode 3, LSB first: send 81, receive 01
      @(negedge PCLK);
      cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b1; sclk_in = 1'b1;
      wait_half(1'b0);
      pulse_load(8'h81);
      begin_frame();
      xfer(8'h01, 8, 1'b0, mi_a);
      end_frame();
      check("m3_miso_byte", mi_a, 8'h81);
      check("m3_rx_data", rx_data, 8'h01);
      pulse_read();

      // Back to back 11, 22 with no read: overflow keeps first byte
      @(negedge PCLK);
      cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sclk_in = 1'b0;
      wait_half(1'b0);
      pulse_load(8'hF0);
      begin_frame();
      pulse_load(8'h0F);
      xfer(8'h11, 8, 1'b0, mi_a);
      xfer(8'h22, 8, 1'b0, mi_b);
      end_frame();
      check("b2b_miso_1", mi_a, 8'hF0);
      check("b2b_miso_2", mi_b, 8'h0F);
      check("ovf_rx_data", rx_data, 8'h11);
      check("ovf_rx_full", rx_full, 1'b1);
      check("ovf_set", rx_ovf, 1'b1);
      pulse_ovf_clr();
      check("ovf_clr", rx_ovf, 1'b0);
      pulse_read();

      // Read coincides with second byte completing
      begin_frame();
      xfer(8'h11, 8, 1'b0, mi_a);
      xfer(8'h22, 8, 1'b1, mi_b);
      end_frame();
      check("rdsame_rx_data", rx_data, 8'h22);
      check("rdsame_rx_full", rx_full, 1'b1);
      check("rdsame_no_ovf", rx_ovf, 1'b0);
      pulse_read();

      // Partial byte aborted by ss_n, then a full frame
      begin_frame();
      xfer(8'hFF, 5, 1'b0, mi_a);
      end_frame();
      check("part_rx_full", rx_full, 1'b0);
      check("part_oe", miso_oe, 1'b0);
      check("part_no_ovf", rx_ovf, 1'b0);
      begin_frame();
      xfer(8'hC3, 8, 1'b0, mi_a);
      end_frame();
      check("part_next_rx", rx_data, 8'hC3);
      check("part_next_full", rx_full, 1'b1);

      // Reset pulsed mid-byte with rx full and tx buffer loaded
      begin_frame();
      pulse_load(8'h5A);
      check("prerst_tx_full", tx_empty, 1'b0);
      xfer(8'hE7, 3, 1'b0, mi_a);
      @(negedge PCLK);
      PRESETn = 1'b0;
      ss_n = 1'b1;
      sclk_in = cpol;
      repeat (2) @(negedge PCLK);
      check("mid_rst_rx_data", rx_data, 8'h00);
      check("mid_rst_rx_full", rx_full, 1'b0);
      check("mid_rst_rx_ovf", rx_ovf, 1'b0);
      check("mid_rst_tx_empty", tx_empty, 1'b1);
      check("mid_rst_miso", miso, 1'b0);
      check("mid_rst_oe", miso_oe, 1'b0);
      PRESETn = 1'b1;
      repeat (4) @(negedge PCLK);
      check("post_rst_oe", miso_oe, 1'b0);

      // Second load while buffer full is ignored
      pulse_load(8'h77);
      check("ld1_tx_full", tx_empty, 1'b0);
      pulse_load(8'h99);
      check("ld2_tx_full", tx_empty, 1'b0);
      begin_frame();
      xfer(8'h12, 8, 1'b0, mi_a);
      end_frame();
      check("ld_ignored_miso", mi_a, 8'h77);
      check("ld_rx_data", rx_data, 8'h12);
      check("ld_tx_empty", tx_empty, 1'b1);
      pulse_read();

      // Empty tx buffer sends zeros
      begin_frame();
      xfer(8'h34, 8, 1'b0, mi_a);
      end_frame();
      check("empty_miso", mi_a, 8'h00);
      check("empty_rx_data", rx_data, 8'h34);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SHALL have one clock and reset: PCLK in 1 APB clock, all logic on posedge; PRESETn in 1 asynchronous active-low reset.
REQ-002 SHALL have config inputs, level, sampled every cycle: spe in 1 slave enable; cpol in 1 idle level of SCLK; cpha in 1 0=sample leading edge, 1=sample trailing edge; lsbfe in 1 1=LSB first.
REQ-003 SHALL have serial inputs, asynchronous to PCLK: sclk_in in 1 master clock; ss_n in 1 active-low select; mosi in 1 master data.
REQ-004 SHALL have serial outputs: miso out 1 slave data; miso_oe out 1 output enable.
REQ-005 SHALL have transmit side: tx_data in 8 byte to send; tx_load in 1 one-cycle write strobe; tx_empty out 1 tx buffer free.
REQ-006 SHALL have receive side: rx_data out 8 last received byte; rx_full out 1 unread byte held; rx_read in 1 one-cycle read strobe; rx_ovf out 1 sticky overflow; ovf_clr in 1 one-cycle clear.

Function
REQ-007 SHALL pass sclk_in, ss_n and mosi each through a 2-flop synchronizer, then one further flop for edge detection; sclk high and low phases are each at least 4 PCLK.
REQ-008 SHALL define the leading edge as the synced SCLK leaving cpol level and the trailing edge as returning to it; the sample edge is leading if cpha=0, trailing if cpha=1; the other edge is the shift edge.
REQ-009 SHALL implement FSM IDLE/ACTIVE: IDLE->ACTIVE when synced ss_n falls and spe=1; ACTIVE->IDLE when synced ss_n is high or spe=0.
REQ-010 SHALL, on IDLE->ACTIVE, load shift register from tx buffer, or 8'h00 if tx_empty=1, and clear bit count to 0.
REQ-011 SHALL, on a sample edge in ACTIVE, capture synced mosi into the shift register (enters at LSB if lsbfe=0, at MSB if lsbfe=1) and increment 3-bit bit count.
REQ-012 SHALL, on a shift edge in ACTIVE, shift the register by one toward the output end; for cpha=1 the first leading edge of a byte presents bit 0 without shifting.
REQ-013 SHALL drive miso = shift-register MSB (lsbfe=0) or LSB (lsbfe=1) and miso_oe=1 while ACTIVE; miso=0 and miso_oe=0 in IDLE.
REQ-014 SHALL, on the 8th sample edge (bit count 7->0 wrap), deliver the byte on the next PCLK edge: if rx_full=0, set rx_data to the byte and rx_full=1.
REQ-015 SHALL, at the same 8th sample edge, reload the shift register per REQ-010 rules so back-to-back bytes need no ss_n deassertion.
REQ-016 SHALL set tx_empty=1 whenever the tx buffer is copied into the shift register.
REQ-017 SHALL, on tx_load with tx_empty=1, latch tx_data into the tx buffer and clear tx_empty; tx_load with tx_empty=0 is ignored.
REQ-018 SHALL, when a copy and a tx_load occur in the same cycle, give the copy priority: the new data is latched and tx_empty ends at 0.
REQ-019 SHALL clear rx_full on rx_read; rx_read with rx_full=0 has no effect.
REQ-020 SHALL, on a byte completing while rx_full=1 and rx_read=0, discard the new byte, keep rx_data, and set rx_ovf=1.
REQ-021 SHALL, on a byte completing in the same cycle as rx_read, treat the read first: rx_data gets the new byte, rx_full stays 1, and no overflow occurs.
REQ-022 SHALL clear rx_ovf on ovf_clr unless a new overflow occurs in the same cycle, in which case set wins.
REQ-023 SHALL discard a partial byte on ss_n deassertion or spe=0 mid-byte: no rx_full, no overflow, bit count 0, tx_empty unchanged.

Reset
REQ-024 SHALL, while PRESETn=0: FSM=IDLE, shift register=8'h00, bit count=0, tx buffer=8'h00, tx_empty=1, rx_data=8'h00, rx_full=0, rx_ovf=0, miso=0, miso_oe=0, synchronizer flops=ss_n high and SCLK at reset-time cpol.
REQ-025 SHALL, on reset assertion mid-byte, abort immediately; after release the block waits for a fresh synced ss_n falling edge.

Structure
REQ-026 SHALL keep these in shared package spi_pkg: FSM state encoding IDLE/ACTIVE, DATA_W=8, BITCNT_W=3.
REQ-027 SHALL put the 3-flop synchronizer plus rise/fall detect in sub-module spi_sync_edge, instantiated once for sclk_in and for ss_n; mosi uses synchronizer only.

Verification
REQ-028 SHALL cover: mode 0 (cpol=0, cpha=0, lsbfe=0), tx 8'hA5 loaded, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_full=1; tx_empty=1.
REQ-029 SHALL cover: mode 3 (cpol=1, cpha=1) with lsbfe=1, tx 8'h81, master sends 8'h01 -> miso LSB first 1,0,0,0,0,0,0,1; rx_data=8'h01.
REQ-030 SHALL cover: two back-to-back bytes 8'h11 then 8'h22 with no rx_read -> rx_data=8'h11, rx_ovf=1; ovf_clr -> rx_ovf=0.
REQ-031 SHALL cover: rx_read on the same cycle as the 2nd byte completing -> rx_data=8'h22, rx_full=1, rx_ovf=0.
REQ-032 SHALL cover: ss_n raised after 5 bits -> rx_full=0, miso_oe=0; next full frame of 8'hC3 -> rx_data=8'hC3.
REQ-033 SHALL cover: PRESETn pulsed low after 3 bits -> all REQ-024 values; tx_load ignored while tx_empty=0; empty tx gives miso all zeros.
